dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-master arbiter for the data-memory path (SRAM controller behind the LSU).
- Master 0 is the core LSU port. Master 1 is a secondary requester (debug loader / DMA).
- One transaction is outstanding at a time. Granted requests are forwarded to the single SRAM-controller slave port; the arbiter waits for the slave ack and returns data plus a one-cycle ack to the granted master.
- A watchdog turns a missing slave ack into an error response.

Parameters:
- TIMEOUT_CYC, 255: maximum cycles in BUSY before an error response is forced; legal range 1..2^CNT_W-1.
- CNT_W, 8: width of the watchdog counter.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- m0_req  in  1  master 0 request; level, held until m0_ack
- m0_wr  in  1  1 = write, 0 = read
- m0_addr  in  16  byte address
- m0_wdata  in  32  write data
- m0_bmask  in  4  byte enables
- m0_rdata  out  32  read data; valid while m0_ack=1
- m0_ack  out  1  one-cycle completion pulse
- m0_err  out  1  timeout flag; valid while m0_ack=1
- m1_req, m1_wr, m1_addr, m1_wdata, m1_bmask, m1_rdata, m1_ack, m1_err: same directions, widths and meanings as the m0_* ports, for master 1
- s_addr  out  16  to slave
- s_wdata  out  32  to slave
- s_bmask  out  4  to slave
- s_wren  out  1  slave write strobe; level
- s_rden  out  1  slave read strobe; level
- s_rdata  in  32  slave read data; valid with s_ack
- s_ack  in  1  slave completion
- busy  out  1  FSM is not in IDLE

Behaviour:
- States: IDLE, BUSY, RESP.
- Reset (rst=1 at a clk edge):
  - FSM goes to IDLE; last_grant=1, so master 0 wins the first tie.
  - All outputs go to 0; latched command, rdata and counter are cleared.
  - Reset in BUSY or RESP abandons the transaction: no ack is issued, and s_wren/s_rden are 0 from the next cycle.
- IDLE:
  - If any req=1, grant one master and latch its wr/addr/wdata/bmask, then go to BUSY.
  - Arbitration: a sole requester wins. If both request, the master not equal to last_grant wins (round-robin).
  - Request fields are sampled only in IDLE; changes during BUSY are ignored.
- BUSY:
  - s_addr/s_wdata/s_bmask are driven from the latched command.
  - s_wren = latched wr; s_rden = ~latched wr. Strobes are held for every BUSY cycle.
  - Watchdog counter starts at 0 on entry and increments each BUSY cycle.
  - s_ack=1: capture s_rdata (captured for writes too), clear err, go to RESP.
  - Otherwise, when the counter reaches TIMEOUT_CYC-1 (after TIMEOUT_CYC BUSY cycles): set err=1, set rdata=0, go to RESP.
  - s_ack on the same cycle as the timeout: s_ack wins, err=0.
- RESP:
  - Strobes are 0.
  - mN_ack=1 for exactly this one cycle, only for the granted master; rdata and err are valid.
  - Non-granted master's ack/err/rdata outputs stay 0.
  - last_grant is set to the granted master; next state is IDLE.
- Handshake and latency:
  - Request seen in IDLE at cycle 0 → strobes from cycle 1 → s_ack at cycle k (k≥1) → mN_ack at cycle k+1.
  - Minimum round trip is 3 cycles; back-to-back throughput is one transaction per ≥3 cycles.
- Master rule: a master deasserts req in the cycle after it sees its ack. A req still high in IDLE is treated as a new transaction.
- s_ack while the FSM is in IDLE or RESP is ignored.
- Addresses pass through unmodified; address decoding stays in the LSU.
- busy=1 in BUSY and RESP.

Test Plan:
- Single read: m0 reads addr 0x0010, slave acks 2 cycles after strobe with s_rdata=0xDEADBEEF → s_rden high 2 cycles, m0_ack one cycle later with m0_rdata=0xDEADBEEF, m0_err=0, m1_ack stays 0.
- Single write: m1 writes addr 0x0124, data 0xA5A5_1234, bmask 4'b0011 → s_wren=1, s_addr=0x0124, s_bmask=4'b0011 until s_ack, then m1_ack=1, m1_err=0.
- Round-robin: m0_req and m1_req both held high for 4 transactions from reset → grant order m0, m1, m0, m1; each ack is a one-cycle pulse.
- Timeout: TIMEOUT_CYC=4, slave never acks → exactly 4 BUSY cycles, then m0_ack=1, m0_err=1, m0_rdata=0; s_ack on the 4th BUSY cycle instead → err=0.
- Reset mid-operation: assert rst during BUSY → next cycle all outputs 0, no ack; after release, a new m1 request is serviced normally.
- Stability: change m0_addr from 0x0010 to 0x0020 during BUSY → s_addr stays 0x0010 until the transaction completes.

Source files
------------

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : dmem_arbiter
// Purpose  : Round-robin two-master arbiter in front of the data-memory SRAM
//            controller, with a watchdog that converts a lost ack into an error.
// Revision : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int TIMEOUT_CYC = 255,
    parameter int CNT_W       = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        m0_req,
    input  logic        m0_wr,
    input  logic [15:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_bmask,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    output logic        m0_err,
    input  logic        m1_req,
    input  logic        m1_wr,
    input  logic [15:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_bmask,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic        m1_err,
    output logic [15:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_bmask,
    output logic        s_wren,
    output logic        s_rden,
    input  logic [31:0] s_rdata,
    input  logic        s_ack,
    output logic        busy
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_busy = 2'd1;
    localparam logic [1:0] c_resp = 2'd2;

    localparam logic [CNT_W-1:0] c_timeout_last = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);

    logic [1:0]       r_state;
    logic             r_last_grant;
    logic             r_gnt;
    logic             r_wr;
    logic [15:0]      r_addr;
    logic [31:0]      r_wdata;
    logic [3:0]       r_bmask;
    logic [31:0]      r_rdata;
    logic             r_err;
    logic [CNT_W-1:0] r_cnt;

    logic w_pick;
    logic w_in_busy;
    logic w_resp0;
    logic w_resp1;

    // Under contention the master that did not win last time is served.
    assign w_pick = (m0_req && m1_req) ? ~r_last_grant : m1_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= c_idle;
            r_last_grant <= 1'b1;
            r_gnt        <= 1'b0;
            r_wr         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_bmask      <= '0;
            r_rdata      <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (m0_req || m1_req) begin
                        r_gnt   <= w_pick;
                        r_wr    <= w_pick ? m1_wr    : m0_wr;
                        r_addr  <= w_pick ? m1_addr  : m0_addr;
                        r_wdata <= w_pick ? m1_wdata : m0_wdata;
                        r_bmask <= w_pick ? m1_bmask : m0_bmask;
                        r_cnt   <= '0;
                        r_state <= c_busy;
                    end
                end
                c_busy: begin
                    if (s_ack) begin
                        r_rdata <= s_rdata;
                        r_err   <= 1'b0;
                        r_state <= c_resp;
                    end else if (r_cnt == c_timeout_last) begin
                        r_rdata <= '0;
                        r_err   <= 1'b1;
                        r_state <= c_resp;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_one;
                    end
                end
                c_resp: begin
                    r_last_grant <= r_gnt;
                    r_state      <= c_idle;
                end
                default: r_state <= c_idle;
            endcase
        end
    end

    // Outputs decode from registered state only, so they never depend on inputs.
    assign w_in_busy = (r_state == c_busy);
    assign w_resp0   = (r_state == c_resp) && !r_gnt;
    assign w_resp1   = (r_state == c_resp) && r_gnt;

    assign busy    = (r_state != c_idle);
    assign s_wren  = w_in_busy && r_wr;
    assign s_rden  = w_in_busy && !r_wr;
    assign s_addr  = w_in_busy ? r_addr  : '0;
    assign s_wdata = w_in_busy ? r_wdata : '0;
    assign s_bmask = w_in_busy ? r_bmask : '0;

    assign m0_ack   = w_resp0;
    assign m0_err   = w_resp0 && r_err;
    assign m0_rdata = w_resp0 ? r_rdata : '0;
    assign m1_ack   = w_resp1;
    assign m1_err   = w_resp1 && r_err;
    assign m1_rdata = w_resp1 ? r_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_arbiter
// Purpose  : Directed plus randomized bench for dmem_arbiter against a
//            transaction-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    localparam int c_t = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 0, m0_wr = 0, m1_req = 0, m1_wr = 0;
    logic [15:0] m0_addr = '0, m1_addr = '0;
    logic [31:0] m0_wdata = '0, m1_wdata = '0;
    logic [3:0]  m0_bmask = '0, m1_bmask = '0;
    logic [31:0] m0_rdata, m1_rdata, s_wdata;
    logic        m0_ack, m0_err, m1_ack, m1_err;
    logic [15:0] s_addr;
    logic [3:0]  s_bmask;
    logic        s_wren, s_rden, busy;
    logic [31:0] s_rdata = '0;
    logic        s_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.TIMEOUT_CYC(c_t), .CNT_W(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_wr(m0_wr), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_bmask(m0_bmask), .m0_rdata(m0_rdata), .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_wr(m1_wr), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_bmask(m1_bmask), .m1_rdata(m1_rdata), .m1_ack(m1_ack), .m1_err(m1_err),
        .s_addr(s_addr), .s_wdata(s_wdata), .s_bmask(s_bmask), .s_wren(s_wren),
        .s_rden(s_rden), .s_rdata(s_rdata), .s_ack(s_ack), .busy(busy)
    );

    // Reference model: one in-flight transaction with its age in busy cycles.
    int          ph = 0;          // 0 idle, 1 waiting on slave, 2 responding
    int          age = 0;
    bit          last = 1'b1;
    bit          g = 1'b0;
    bit          t_wr = 1'b0;
    logic [15:0] t_addr = '0;
    logic [31:0] t_wdata = '0;
    logic [3:0]  t_bmask = '0;
    logic [31:0] t_rd = '0;
    bit          t_err = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_next();
        if (rst) begin
            ph   = 0;
            last = 1'b1;
        end else if (ph == 0) begin
            if (m0_req || m1_req) begin
                g       = (m0_req && m1_req) ? !last : m1_req;
                t_wr    = g ? m1_wr    : m0_wr;
                t_addr  = g ? m1_addr  : m0_addr;
                t_wdata = g ? m1_wdata : m0_wdata;
                t_bmask = g ? m1_bmask : m0_bmask;
                age     = 0;
                ph      = 1;
            end
        end else if (ph == 1) begin
            age++;
            if (s_ack) begin
                t_rd = s_rdata; t_err = 1'b0; ph = 2;
            end else if (age == c_t) begin
                t_rd = '0; t_err = 1'b1; ph = 2;
            end
        end else begin
            last = g;
            ph   = 0;
        end
    endtask

    task automatic compare();
        bit bsy = (ph == 1);
        bit r0  = (ph == 2) && !g;
        bit r1  = (ph == 2) && g;
        chk("busy", 32'(busy), 32'(ph != 0));
        chk("s_wren", 32'(s_wren), 32'(bsy && t_wr));
        chk("s_rden", 32'(s_rden), 32'(bsy && !t_wr));
        if (bsy) begin
            chk("s_addr", 32'(s_addr), 32'(t_addr));
            chk("s_wdata", s_wdata, t_wdata);
            chk("s_bmask", 32'(s_bmask), 32'(t_bmask));
        end
        chk("m0_ack", 32'(m0_ack), 32'(r0));
        chk("m1_ack", 32'(m1_ack), 32'(r1));
        chk("m0_err", 32'(m0_err), 32'(r0 && t_err));
        chk("m1_err", 32'(m1_err), 32'(r1 && t_err));
        chk("m0_rdata", m0_rdata, r0 ? t_rd : 32'h0);
        chk("m1_rdata", m1_rdata, r1 ? t_rd : 32'h0);
    endtask

    // Inputs for the current cycle are already applied; advance one clock.
    task automatic tick();
        model_next();
        @(posedge clk);
        #1;
        compare();
    endtask

    bit drop0 = 0, drop1 = 0;

    initial begin
        tick();
        chk("reset_busy", 32'(busy), 32'h0);
        chk("reset_ack", 32'(m0_ack | m1_ack), 32'h0);
        rst = 1'b0;

        // Single read from m0, slave acks on the second strobe cycle.
        m0_req = 1; m0_wr = 0; m0_addr = 16'h0010;
        tick();
        chk("rd_rden_c1", 32'(s_rden), 32'h1);
        chk("rd_addr_c1", 32'(s_addr), 32'h0010);
        m0_addr = 16'h0020;
        tick();
        chk("rd_rden_c2", 32'(s_rden), 32'h1);
        chk("stable_addr", 32'(s_addr), 32'h0010);
        s_ack = 1; s_rdata = 32'hDEADBEEF;
        tick();
        chk("rd_ack", 32'(m0_ack), 32'h1);
        chk("rd_data", m0_rdata, 32'hDEADBEEF);
        chk("rd_m1_quiet", 32'(m1_ack), 32'h0);
        m0_req = 0; s_ack = 0;
        tick();

        // Single write from m1.
        m1_req = 1; m1_wr = 1; m1_addr = 16'h0124; m1_wdata = 32'hA5A5_1234; m1_bmask = 4'b0011;
        tick();
        chk("wr_wren", 32'(s_wren), 32'h1);
        chk("wr_addr", 32'(s_addr), 32'h0124);
        chk("wr_bmask", 32'(s_bmask), 32'h3);
        s_ack = 1;
        tick();
        chk("wr_ack", 32'(m1_ack), 32'h1);
        chk("wr_err", 32'(m1_err), 32'h0);
        m1_req = 0; s_ack = 0;
        tick();

        // Round-robin from reset with both masters continuously requesting.
        rst = 1; tick(); rst = 0;
        m0_req = 1; m1_req = 1; m0_wr = 0; m1_wr = 0; s_ack = 1;
        for (int i = 0; i < 4; i++) begin
            s_rdata = 32'(i);
            tick(); tick();
            chk("rr_m0_ack", 32'(m0_ack), 32'((i % 2) == 0));
            chk("rr_m1_ack", 32'(m1_ack), 32'((i % 2) == 1));
            tick();
        end
        m0_req = 0; m1_req = 0; s_ack = 0;
        tick();

        // Watchdog expiry, then an ack landing on the final busy cycle.
        m0_req = 1; m0_wr = 0; m0_addr = 16'h0040;
        tick(); tick(); tick(); tick();
        chk("to_still_busy", 32'(s_rden), 32'h1);
        tick();
        chk("to_ack", 32'(m0_ack), 32'h1);
        chk("to_err", 32'(m0_err), 32'h1);
        chk("to_rdata", m0_rdata, 32'h0);
        m0_req = 0;
        tick();
        m0_req = 1;
        tick(); tick(); tick(); tick();
        s_ack = 1; s_rdata = 32'h1234_5678;
        tick();
        chk("to_race_err", 32'(m0_err), 32'h0);
        chk("to_race_data", m0_rdata, 32'h1234_5678);
        m0_req = 0; s_ack = 0;
        tick();

        // Reset while busy abandons the transaction; m1 is then serviced.
        m0_req = 1;
        tick();
        rst = 1; m0_req = 0;
        tick();
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_rden", 32'(s_rden), 32'h0);
        chk("rst_noack", 32'(m0_ack), 32'h0);
        rst = 0; m1_req = 1; m1_wr = 0;
        tick();
        s_ack = 1; s_rdata = 32'hCAFE_F00D;
        tick();
        chk("post_rst_ack", 32'(m1_ack), 32'h1);
        chk("post_rst_data", m1_rdata, 32'hCAFE_F00D);
        m1_req = 0; s_ack = 0;
        tick();

        // Randomized traffic with masters obeying the request/ack handshake.
        for (int c = 0; c < 4000; c++) begin
            if (m0_req && ph == 2 && !g) drop0 = 1;
            else if (drop0) begin m0_req = 0; drop0 = 0; end
            else if (!m0_req) m0_req = ($urandom % 3 == 0);
            if (m1_req && ph == 2 && g) drop1 = 1;
            else if (drop1) begin m1_req = 0; drop1 = 0; end
            else if (!m1_req) m1_req = ($urandom % 3 == 0);
            m0_wr = $urandom % 2;  m1_wr = $urandom % 2;
            m0_addr = 16'($urandom); m1_addr = 16'($urandom);
            m0_wdata = $urandom;   m1_wdata = $urandom;
            m0_bmask = 4'($urandom); m1_bmask = 4'($urandom);
            s_ack = ($urandom % 4 == 0);
            s_rdata = $urandom;
            rst = ($urandom % 150 == 0);
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
